// File: rtl/polar_pkg.sv
// Shared types and defaults for the sequential polar mother-code-length calculator.
package polar_pkg;

    typedef enum logic [1:0] {
        RM_REPETITION = 2'd0,
        RM_PUNCTURING = 2'd1,
        RM_SHORTENING = 2'd2
    } rm_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_DECIDE = 2'd2,
        ST_DONE   = 2'd3
    } getn_state_e;

    localparam int NMIN_DEF    = 5;
    localparam int NMAX_DL_DEF = 9;
    localparam int NMAX_UL_DEF = 10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/polar_clog2_scan.sv
// Serial MSB-first leading-one detector: clog2_o = (first cnt with value[cnt]==1) + 1, or 0.
module polar_clog2_scan
    import polar_pkg::*;
#(
    parameter int WIDTH = 14,
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] value_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             start_i,
    input  logic             en_i,
    output logic [CNT_W:0]   clog2_o
);

    localparam int EXT_W = 1 << CNT_W;

    if (EXT_W < WIDTH) begin : g_bad_width
        $error("polar_clog2_scan: CNT_W too small for WIDTH");
    end

    logic [EXT_W-1:0] ext_s;
    logic             bit_s;
    logic             found_q;
    logic [CNT_W:0]   clog2_q;

    // Counter may address bits above WIDTH; those read as zero.
    assign ext_s   = EXT_W'(value_i);
    assign bit_s   = ext_s[cnt_i];
    assign clog2_o = clog2_q;

    // Latch the first set bit seen while scanning downwards.
    always_ff @(posedge clk_i) begin
        if (rst_i || start_i) begin
            found_q <= 1'b0;
            clog2_q <= '0;
        end else if (en_i && !found_q && bit_s) begin
            found_q <= 1'b1;
            clog2_q <= {1'b0, cnt_i} + {{CNT_W{1'b0}}, 1'b1};
        end else begin
            found_q <= found_q;
            clog2_q <= clog2_q;
        end
    end

endmodule

// File: rtl/polar_getn_seq.sv
// Sequential polar mother-code exponent / rate-matching mode calculator with
// valid/ready handshakes on both sides and a fixed scan-based latency.
module polar_getn_seq
    import polar_pkg::*;
#(
    parameter int K_W     = 10,
    parameter int E_W     = 14,
    parameter int NMIN    = NMIN_DEF,
    parameter int NMAX_DL = NMAX_DL_DEF,
    parameter int NMAX_UL = NMAX_UL_DEF
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [K_W-1:0] K_i,
    input  logic [E_W-1:0] E_i,
    input  logic           ul_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [3:0]     n_o,
    output rm_mode_e       mode_o,
    output logic           err_o
);

    localparam int KX_W  = K_W + 3;
    localparam int W     = max_int(E_W, KX_W);
    localparam int CNT_W = $clog2(W);
    localparam int CL_W  = CNT_W + 1;
    localparam int PW    = E_W + K_W + 4;

    if (!(NMIN >= 0 && NMIN <= NMAX_DL && NMAX_DL <= NMAX_UL && NMAX_UL <= 15)) begin : g_bad_nparams
        $error("polar_getn_seq: need 0 <= NMIN <= NMAX_DL <= NMAX_UL <= 15");
    end

    getn_state_e    state_q;
    logic [K_W-1:0] k_q;
    logic [E_W-1:0] e_q;
    logic           ul_q;
    logic [E_W-1:0] xe_q;
    logic [KX_W-1:0] xk_q;
    logic [CNT_W-1:0] cnt_q;
    logic           out_valid_q;
    logic [3:0]     n_q;
    rm_mode_e       mode_q;
    logic           err_q;

    logic           start_s;
    logic           scan_en_s;
    logic [CL_W-1:0] cl2e_s;
    logic [CL_W-1:0] cl2k_s;

    assign start_s     = (state_q == ST_IDLE) && in_valid_i;
    assign scan_en_s   = (state_q == ST_SCAN);
    assign in_ready_o  = (state_q == ST_IDLE) && !rst_i;
    assign out_valid_o = out_valid_q;
    assign n_o         = n_q;
    assign mode_o      = mode_q;
    assign err_o       = err_q;

    polar_clog2_scan #(.WIDTH(E_W), .CNT_W(CNT_W)) u_scan_e (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .value_i (xe_q),
        .cnt_i   (cnt_q),
        .start_i (start_s),
        .en_i    (scan_en_s),
        .clog2_o (cl2e_s)
    );

    polar_clog2_scan #(.WIDTH(KX_W), .CNT_W(CNT_W)) u_scan_k (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .value_i (xk_q),
        .cnt_i   (cnt_q),
        .start_i (start_s),
        .en_i    (scan_en_s),
        .clog2_o (cl2k_s)
    );

    logic [PW-1:0] e_ext_s, k_ext_s, e8_s, k16_s, e9_s, e7_s, thr_s, pow_s;
    logic          lo_s;
    int            nmax_s, n1_s, nc_s;
    logic [3:0]    n_d;
    rm_mode_e      mode_d;
    logic          err_d;

    // Decision arithmetic: choose n1, clamp, classify the rate-matching mode.
    always_comb begin
        e_ext_s = PW'(e_q);
        k_ext_s = PW'(k_q);
        e8_s    = e_ext_s << 3;
        k16_s   = k_ext_s << 4;
        e9_s    = e_ext_s * PW'(9);
        e7_s    = e_ext_s * PW'(7);
        thr_s   = (cl2e_s != '0) ? (PW'(9) << (cl2e_s - CL_W'(1))) : '0;
        lo_s    = (cl2e_s != '0) && (e8_s <= thr_s) && (k16_s < e9_s);
        nmax_s  = ul_q ? NMAX_UL : NMAX_DL;
        n1_s    = lo_s ? (int'(cl2e_s) - 1) : int'(cl2e_s);
        nc_s    = (int'(cl2k_s) < n1_s) ? int'(cl2k_s) : n1_s;
        nc_s    = (nmax_s < nc_s) ? nmax_s : nc_s;
        nc_s    = (nc_s < NMIN) ? NMIN : nc_s;
        err_d   = (k_q == '0) || (e_q == '0) || (e_ext_s <= k_ext_s);
        n_d     = err_d ? 4'(NMIN) : 4'(nc_s);
        pow_s   = PW'(1) << n_d;
        mode_d  = (err_d || (e_ext_s >= pow_s)) ? RM_REPETITION :
                  (k16_s <= e7_s)               ? RM_PUNCTURING : RM_SHORTENING;
    end

    // Control FSM with registered result outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            e_q         <= '0;
            ul_q        <= 1'b0;
            xe_q        <= '0;
            xk_q        <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            n_q         <= 4'd0;
            mode_q      <= RM_REPETITION;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        k_q     <= K_i;
                        e_q     <= E_i;
                        ul_q    <= ul_i;
                        xe_q    <= E_i - E_W'(1);
                        xk_q    <= {K_i, 3'b000} - KX_W'(1);
                        cnt_q   <= CNT_W'(W - 1);
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_DECIDE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_DECIDE: begin
                    n_q         <= n_d;
                    mode_q      <= mode_d;
                    err_q       <= err_d;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_polar_getn_seq.sv
// Directed self-checking bench for polar_getn_seq with hand-computed expectations.
module tb_polar_getn_seq;
    import polar_pkg::*;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] k_in;
    logic [13:0] e_in;
    logic       ul;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] n_out;
    rm_mode_e   mode_out;
    logic       err_out;

    int err_cnt = 0;
    int chk_cnt = 0;

    localparam int LAT = 16;

    polar_getn_seq dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .K_i         (k_in),
        .E_i         (e_in),
        .ul_i        (ul),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .n_o         (n_out),
        .mode_o      (mode_out),
        .err_o       (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one request and wait for the result; latency counts the accepting edge as 1.
    task automatic start_req(input logic [9:0] k, input logic [13:0] e, input logic u);
        @(negedge clk);
        k_in     = k;
        e_in     = e;
        ul       = u;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        k_in     = 10'd1023;
        e_in     = 14'd1;
        ul       = ~u;
    endtask

    task automatic wait_result(input string tag, output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'(LAT));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_eq({tag, "_rdy_after"}, 32'(in_ready), 32'd1);
        check_eq({tag, "_vld_after"}, 32'(out_valid), 32'd0);
    endtask

    task automatic do_req(input string tag, input logic [9:0] k, input logic [13:0] e,
                          input logic u, input logic [3:0] exp_n, input rm_mode_e exp_m,
                          input logic exp_e);
        int lat;
        start_req(k, e, u);
        wait_result(tag, lat);
        check_eq({tag, "_n"}, 32'(n_out), 32'(exp_n));
        check_eq({tag, "_mode"}, 32'(mode_out), 32'(exp_m));
        check_eq({tag, "_err"}, 32'(err_out), 32'(exp_e));
        release_out(tag);
    endtask

    initial begin
        int lat;
        int bad;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        k_in      = 10'd0;
        e_in      = 14'd0;
        ul        = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_n", 32'(n_out), 32'd0);
        check_eq("rst_mode", 32'(mode_out), 32'd0);
        check_eq("rst_err", 32'(err_out), 32'd0);
        check_eq("idle_in_ready", 32'(in_ready), 32'd1);

        do_req("dl_56_864",  10'd56,  14'd864,  1'b0, 4'd9,  RM_REPETITION, 1'b0);
        do_req("dl_20_100",  10'd20,  14'd100,  1'b0, 4'd7,  RM_PUNCTURING, 1'b0);
        do_req("dl_100_140", 10'd100, 14'd140,  1'b0, 4'd8,  RM_SHORTENING, 1'b0);
        do_req("dl_20_140",  10'd20,  14'd140,  1'b0, 4'd7,  RM_REPETITION, 1'b0);
        do_req("dl_18_20",   10'd18,  14'd20,   1'b0, 4'd5,  RM_SHORTENING, 1'b0);
        do_req("dl_140_8192",10'd140, 14'd8192, 1'b0, 4'd9,  RM_REPETITION, 1'b0);
        do_req("ul_140_8192",10'd140, 14'd8192, 1'b1, 4'd10, RM_REPETITION, 1'b0);
        do_req("err_60_50",  10'd60,  14'd50,   1'b0, 4'd5,  RM_REPETITION, 1'b1);
        do_req("err_k0",     10'd0,   14'd100,  1'b0, 4'd5,  RM_REPETITION, 1'b1);

        // Backpressure: result held, second request ignored.
        start_req(10'd20, 14'd100, 1'b0);
        wait_result("bp", lat);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            k_in     = 10'd100;
            e_in     = 14'd140;
            if (!out_valid || n_out != 4'd7 || mode_out != RM_PUNCTURING || err_out || in_ready)
                bad++;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_eq("bp_stable", 32'(bad), 32'd0);
        check_eq("bp_n", 32'(n_out), 32'd7);
        release_out("bp");
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        check_eq("bp_no_ghost", 32'(bad), 32'd0);

        // Reset in the middle of a scan aborts the request.
        start_req(10'd56, 14'd864, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_vld", 32'(out_valid), 32'd0);
        check_eq("abort_n", 32'(n_out), 32'd0);
        check_eq("abort_mode", 32'(mode_out), 32'd0);
        check_eq("abort_err", 32'(err_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_idle", 32'(in_ready), 32'd1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        check_eq("abort_no_result", 32'(bad), 32'd0);
        do_req("post_abort", 10'd100, 14'd140, 1'b0, 4'd8, RM_SHORTENING, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
